// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter family:
// parity mode constants, receiver FSM encoding and baud divisor helper.
package serial_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Clocks per oversample tick: floor(clk / (baud * os)), never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: counts 0..DIV-1 and emits a one-clock tick
// at DIV-1. A synchronous clear holds the counter at 0 so the tick phase
// can be re-aligned to an external event (e.g. a start-bit edge).
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, held at zero while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised UART receiver with 2-flop synchroniser, 3-sample majority
// vote around bit centre and a one-entry valid/ready holding register.
//
// Handshake: rx_valid means the holding register is full; a transfer
// happens on any clock where rx_valid && rx_ready. rx_data and the error
// flags are stable while rx_valid is 1. A new frame arriving while the
// register is full and not being accepted is dropped and overrun pulses.
module serial_rx_param
  import serial_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0] M_LO    = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] M_MID   = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] M_HI    = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2);
  localparam logic            ODD_INV   = (PARITY == PARITY_ODD);

  // Reject unsupported configurations at elaboration time.
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("serial_rx_param: OVERSAMPLE must be even and in 8..32");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("serial_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("serial_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_rx_param: STOP_BITS must be 1 or 2");
  end

  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [SC_W-1:0]      sc;
  logic [BI_W-1:0]      bit_idx;
  logic                 stop_idx;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_err_int;
  logic                 frame_err_int;
  logic                 done;
  logic                 tick;
  logic                 maj;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (reset),
    .clear (state == ST_IDLE),
    .tick  (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Majority of the two stored samples and the live sample at M+1.
  assign maj = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  assign busy = (state != ST_IDLE);

  // Frame FSM: start validation, data shift, parity and stop sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      sc             <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      samp_a         <= 1'b0;
      samp_b         <= 1'b0;
      shreg          <= '0;
      parity_err_int <= 1'b0;
      frame_err_int  <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!en) begin
        state    <= ST_IDLE;
        sc       <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (rx_prev && !rx_s) begin
          state          <= ST_START;
          sc             <= '0;
          bit_idx        <= '0;
          stop_idx       <= 1'b0;
          parity_err_int <= 1'b0;
          frame_err_int  <= 1'b0;
        end
      end else if (tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (sc == M_LO)  samp_a <= rx_s;
        if (sc == M_MID) samp_b <= rx_s;
        case (state)
          ST_START: begin
            if (sc == M_HI && maj) begin
              state <= ST_IDLE;
            end else if (sc == SC_LAST) begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sc == M_HI) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (sc == SC_LAST) begin
              if (bit_idx == BI_LAST) begin
                bit_idx <= '0;
                state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (sc == M_HI) parity_err_int <= (maj != ((^shreg) ^ ODD_INV));
            if (sc == SC_LAST) state <= ST_STOP;
          end
          ST_STOP: begin
            if (sc == M_HI) begin
              if (!maj) frame_err_int <= 1'b1;
              if (stop_idx == STOP_LAST) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else if (sc == SC_LAST) begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= parity_err_int;
          rx_frame_err  <= frame_err_int;
          rx_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param. Three receivers share one serial
// line: 8N1 (a), 7E1 (b) and 8N2 (c). 16 clocks per bit.
module tb_serial_rx_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic rx = 1'b1;
  logic rdy_a = 1'b1;
  logic rdy_b = 1'b1;
  logic rdy_c = 1'b1;

  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [7:0] data_c;
  logic perr_a, ferr_a, valid_a, ovr_a, busy_a;
  logic perr_b, ferr_b, valid_b, ovr_b, busy_b;
  logic perr_c, ferr_c, valid_c, ovr_c, busy_c;

  int n_checks = 0;
  int n_fail = 0;

  // Monitor captures
  int acc_a_n = 0, acc_b_n = 0, acc_c_n = 0;
  int ovr_a_n = 0;
  logic [7:0] acc_a_data, acc_c_data;
  logic [6:0] acc_b_data;
  logic acc_a_perr, acc_a_ferr, acc_b_perr, acc_b_ferr, acc_c_perr, acc_c_ferr;

  // clock / reset block
  always #5 clk = ~clk;

  serial_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .rx(rx), .rx_data(data_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a));

  serial_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .en(en), .rx(rx), .rx_data(data_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_valid(valid_b),
    .rx_ready(rdy_b), .overrun(ovr_b), .busy(busy_b));

  serial_rx_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .en(en), .rx(rx), .rx_data(data_c),
    .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .rx_valid(valid_c),
    .rx_ready(rdy_c), .overrun(ovr_c), .busy(busy_c));

  // Record every accepted frame and every overrun cycle.
  always @(negedge clk) begin
    if (valid_a && rdy_a) begin
      acc_a_n++; acc_a_data = data_a; acc_a_perr = perr_a; acc_a_ferr = ferr_a;
    end
    if (valid_b && rdy_b) begin
      acc_b_n++; acc_b_data = data_b; acc_b_perr = perr_b; acc_b_ferr = ferr_b;
    end
    if (valid_c && rdy_c) begin
      acc_c_n++; acc_c_data = data_c; acc_c_perr = perr_c; acc_c_ferr = ferr_c;
    end
    if (ovr_a) ovr_a_n++;
  end

  // driver tasks
  task automatic line_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Start bit, then nbits line bits LSB first (data, parity, stops), then idle.
  task automatic send_bits(input logic [15:0] bits, input int nbits);
    line_bit(1'b0, 16);
    for (int i = 0; i < nbits; i++) line_bit(bits[i], 16);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
    n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %h expected 00", data_a); end
    n_checks++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags_a: got %b expected 000", {perr_a, ferr_a, ovr_a}); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    n_checks++; if ({valid_b, valid_c, busy_b, busy_c} !== 4'b0000) begin n_fail++; $display("FAIL reset_bc: got %b expected 0000", {valid_b, valid_c, busy_b, busy_c}); end
    reset = 1'b0;
    idle(20);
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL idle_valid_a: got %b expected 0", valid_a); end
  endtask

  task automatic test_8n1;
    int base, obase;
    base = acc_a_n; obase = ovr_a_n;
    send_bits({7'h00, 1'b1, 8'hA5}, 9);
    idle(40);
    n_checks++; if (acc_a_n !== base + 1) begin n_fail++; $display("FAIL 8n1_count: got %0d expected %0d", acc_a_n - base, 1); end
    n_checks++; if (acc_a_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h expected a5", acc_a_data); end
    n_checks++; if ({acc_a_perr, acc_a_ferr} !== 2'b00) begin n_fail++; $display("FAIL 8n1_flags: got %b expected 00", {acc_a_perr, acc_a_ferr}); end
    n_checks++; if (ovr_a_n !== obase) begin n_fail++; $display("FAIL 8n1_overrun: got %0d expected 0", ovr_a_n - obase); end
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL 8n1_valid_drop: got %b expected 0", valid_a); end
    idle(200);
  endtask

  task automatic test_parity;
    int base;
    logic [6:0] d;
    logic good_par;
    d = 7'h35;
    good_par = ^d;  // even parity bit
    base = acc_b_n;
    send_bits({7'h00, 1'b1, ~good_par, d}, 9);
    idle(40);
    n_checks++; if (acc_b_n !== base + 1) begin n_fail++; $display("FAIL par_bad_count: got %0d expected 1", acc_b_n - base); end
    n_checks++; if (acc_b_data !== 7'h35) begin n_fail++; $display("FAIL par_bad_data: got %h expected 35", acc_b_data); end
    n_checks++; if ({acc_b_perr, acc_b_ferr} !== 2'b10) begin n_fail++; $display("FAIL par_bad_flags: got %b expected 10", {acc_b_perr, acc_b_ferr}); end
    idle(200);
    base = acc_b_n;
    send_bits({7'h00, 1'b1, good_par, d}, 9);
    idle(40);
    n_checks++; if (acc_b_n !== base + 1) begin n_fail++; $display("FAIL par_ok_count: got %0d expected 1", acc_b_n - base); end
    n_checks++; if (acc_b_data !== 7'h35) begin n_fail++; $display("FAIL par_ok_data: got %h expected 35", acc_b_data); end
    n_checks++; if ({acc_b_perr, acc_b_ferr} !== 2'b00) begin n_fail++; $display("FAIL par_ok_flags: got %b expected 00", {acc_b_perr, acc_b_ferr}); end
    idle(200);
  endtask

  task automatic test_two_stop;
    int base;
    base = acc_c_n;
    send_bits({6'h00, 2'b11, 8'hC3}, 10);
    idle(40);
    n_checks++; if (acc_c_n !== base + 1) begin n_fail++; $display("FAIL stop2_ok_count: got %0d expected 1", acc_c_n - base); end
    n_checks++; if ({acc_c_data, acc_c_ferr} !== {8'hC3, 1'b0}) begin n_fail++; $display("FAIL stop2_ok: got %h/%b expected c3/0", acc_c_data, acc_c_ferr); end
    idle(200);
    base = acc_c_n;
    send_bits({6'h00, 2'b01, 8'h3C}, 10);
    idle(40);
    n_checks++; if (acc_c_n !== base + 1) begin n_fail++; $display("FAIL stop2_bad_count: got %0d expected 1", acc_c_n - base); end
    n_checks++; if (acc_c_data !== 8'h3C) begin n_fail++; $display("FAIL stop2_bad_data: got %h expected 3c", acc_c_data); end
    n_checks++; if ({acc_c_perr, acc_c_ferr} !== 2'b01) begin n_fail++; $display("FAIL stop2_bad_flags: got %b expected 01", {acc_c_perr, acc_c_ferr}); end
    idle(200);
  endtask

  task automatic test_overrun;
    int obase;
    obase = ovr_a_n;
    rdy_a = 1'b0;
    send_bits({7'h00, 1'b1, 8'h11}, 9);
    send_bits({7'h00, 1'b1, 8'h22}, 9);
    idle(40);
    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", valid_a); end
    n_checks++; if (data_a !== 8'h11) begin n_fail++; $display("FAIL ovr_data: got %h expected 11", data_a); end
    n_checks++; if (ovr_a_n !== obase + 1) begin n_fail++; $display("FAIL ovr_pulse_cycles: got %0d expected 1", ovr_a_n - obase); end
    rdy_a = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_drop: got %b expected 0", valid_a); end
    idle(200);
  endtask

  task automatic test_glitch;
    int base;
    bit seen_idle;
    base = acc_a_n;
    line_bit(1'b0, 6);
    rx = 1'b1;
    seen_idle = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i > 2 && !busy_a) seen_idle = 1'b1;
    end
    n_checks++; if (seen_idle !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
    idle(200);
    n_checks++; if (acc_a_n !== base) begin n_fail++; $display("FAIL glitch_no_frame: got %0d frames expected 0", acc_a_n - base); end
    // 0x00 with a one-clock high spike near centre of bit 3
    base = acc_a_n;
    line_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        line_bit(1'b0, 9); line_bit(1'b1, 1); line_bit(1'b0, 6);
      end else begin
        line_bit(1'b0, 16);
      end
    end
    line_bit(1'b1, 16);
    idle(40);
    n_checks++; if (acc_a_n !== base + 1) begin n_fail++; $display("FAIL spike_count: got %0d expected 1", acc_a_n - base); end
    n_checks++; if ({acc_a_data, acc_a_ferr} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL spike_data: got %h/%b expected 00/0", acc_a_data, acc_a_ferr); end
    idle(200);
  endtask

  task automatic test_abort;
    int base;
    base = acc_a_n;
    // en dropped mid-byte
    line_bit(1'b0, 16 + 3 * 16 + 5);
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b expected 1", busy_a); end
    en = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL en_off_busy: got %b expected 0", busy_a); end
    idle(40);
    en = 1'b1;
    idle(40);
    // reset mid-byte
    line_bit(1'b0, 16);
    line_bit(1'b1, 16);
    line_bit(1'b0, 16 + 5);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy_a, valid_a} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_state: got %b expected 00", {busy_a, valid_a}); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(200);
    n_checks++; if (acc_a_n !== base) begin n_fail++; $display("FAIL abort_no_frame: got %0d frames expected 0", acc_a_n - base); end
    send_bits({7'h00, 1'b1, 8'h5A}, 9);
    idle(40);
    n_checks++; if (acc_a_n !== base + 1) begin n_fail++; $display("FAIL after_abort_count: got %0d expected 1", acc_a_n - base); end
    n_checks++; if ({acc_a_data, acc_a_perr, acc_a_ferr} !== {8'h5A, 2'b00}) begin n_fail++; $display("FAIL after_abort_data: got %h/%b%b expected 5a/00", acc_a_data, acc_a_perr, acc_a_ferr); end
    idle(50);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_overrun();
    test_glitch();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
